// File: rtl/store_narrow_unit_pkg.sv
// Shared types for the store narrowing unit: access-size encodings,
// FSM state set, lane widths and the alignment rule used for trapping.
package store_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned HALF_W = 16;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned LANES  = WORD_W / BYTE_W;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT,
      WRITE,
      DONE
   } state_e;

   // True when the request cannot be performed as a natural-aligned access.
   function automatic logic is_misaligned(input logic [1:0] addr_lo, input size_e size);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_HALF: bad = addr_lo[0];
         SZ_WORD: bad = (addr_lo != 2'b00);
         SZ_RSVD: bad = 1'b1;
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/store_narrow_unit_if.sv
// CPU-side request handshake and data-RAM port of the store narrowing unit.
// master = CPU/RAM environment, slave = the store unit.
interface store_narrow_unit_if;

   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic [1:0]  req_size;
   logic        busy;
   logic        done;
   logic        fault;
   logic [31:0] mem_addr;
   logic        mem_rd_en;
   logic [31:0] mem_rdata;
   logic        mem_wr_en;
   logic [31:0] mem_wdata;

   modport slave (
      input  req_valid, req_addr, req_data, req_size, mem_rdata,
      output req_ready, busy, done, fault, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
   );

   modport master (
      output req_valid, req_addr, req_data, req_size, mem_rdata,
      input  req_ready, busy, done, fault, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
   );

endinterface

// File: rtl/store_narrow_unit_lane_merge.sv
// Combinational lane merge: places the narrowed store data into the
// little-endian lane selected by the low address bits, keeping all other
// bits of the old RAM word. byte_en reports which lanes were replaced.
module store_lane_merge
   import store_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] data,
   input  logic [1:0]  addr_lo,
   input  size_e       size,
   output logic [31:0] merged,
   output logic [3:0]  byte_en
);

   // Lane substitution by access size; halfword and word ignore the low address bits they cannot use.
   always_comb begin
      merged  = old_word;
      byte_en = '0;
      case (size)
         SZ_BYTE: begin
            for (int unsigned i = 0; i < LANES; i++) begin
               if (addr_lo == 2'(i)) begin
                  merged[i*BYTE_W +: BYTE_W] = data[BYTE_W-1:0];
                  byte_en[i]                 = 1'b1;
               end
            end
         end
         SZ_HALF: begin
            if (addr_lo[1]) begin
               merged[HALF_W +: HALF_W] = data[HALF_W-1:0];
               byte_en                  = 4'b1100;
            end else begin
               merged[0 +: HALF_W] = data[HALF_W-1:0];
               byte_en             = 4'b0011;
            end
         end
         SZ_WORD: begin
            merged  = data;
            byte_en = '1;
         end
         default: begin
            merged  = old_word;
            byte_en = '0;
         end
      endcase
   end

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: accepts a byte/half/word store from the CPU MEM
// stage and performs it on word-wide data RAM. Sub-word stores are done as
// read-modify-write; word stores write directly; reserved sizes retire with
// no RAM access. Optional macro MISALIGN_TRAP_EN turns misaligned half/word
// and reserved requests into a no-access completion with fault raised;
// without it misaligned accesses are forced to natural alignment.
module store_narrow_unit
   import store_pkg::*;
#(
   parameter int unsigned RD_LAT = 1
) (
   input logic                clk,
   input logic                reset,
   store_narrow_unit_if.slave bus
);

   localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

   state_e      state_q, state_d;
   logic [31:0] addr_q;
   logic [31:0] data_q;
   logic [31:0] old_q;
   size_e       size_q;
   logic [1:0]  cnt_q;
   logic        accept;
   logic        no_access;
   logic [31:0] merged;
   logic [3:0]  byte_en;
   logic [31:0] be_mask;

   assign accept = bus.req_valid && (state_q == IDLE);

`ifdef MISALIGN_TRAP_EN
   logic fault_q;
   assign no_access = is_misaligned(bus.req_addr[1:0], size_e'(bus.req_size));
`else
   assign no_access = (size_e'(bus.req_size) == SZ_RSVD);
`endif

   store_lane_merge u_merge (
      .old_word (old_q),
      .data     (data_q),
      .addr_lo  (addr_q[1:0]),
      .size     (size_q),
      .merged   (merged),
      .byte_en  (byte_en)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Request latch, read-latency counter and merge (old word) register.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q <= '0;
         data_q <= '0;
         size_q <= SZ_BYTE;
         cnt_q  <= '0;
         old_q  <= '0;
      end else begin
         if (accept) begin
            addr_q <= bus.req_addr;
            data_q <= bus.req_data;
            size_q <= size_e'(bus.req_size);
         end
         if (state_q == READ)      cnt_q <= '0;
         else if (state_q == WAIT) cnt_q <= cnt_q + 2'd1;
         if ((state_q == WAIT) && (cnt_q == LAST_CNT)) old_q <= bus.mem_rdata;
      end
   end

`ifdef MISALIGN_TRAP_EN
   // Fault flag captured at accept, reported alongside done.
   always_ff @(posedge clk) begin
      if (reset)       fault_q <= 1'b0;
      else if (accept) fault_q <= no_access;
   end
`endif

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               if (no_access)                              state_d = DONE;
               else if (size_e'(bus.req_size) == SZ_WORD) state_d = WRITE;
               else                                        state_d = READ;
            end
         end
         READ:    state_d = WAIT;
         WAIT:    if (cnt_q == LAST_CNT) state_d = WRITE;
         WRITE:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      bus.req_ready = (state_q == IDLE) && !reset;
      bus.busy      = (state_q != IDLE);
      bus.done      = (state_q == DONE);
      bus.mem_rd_en = (state_q == READ);
      bus.mem_wr_en = (state_q == WRITE);
      bus.mem_wdata = (state_q == WRITE) ? merged : '0;
      bus.mem_addr  = (state_q != IDLE) ? {addr_q[31:2], 2'b00} : '0;
`ifdef MISALIGN_TRAP_EN
      bus.fault     = (state_q == DONE) && fault_q;
`else
      bus.fault     = 1'b0;
`endif
   end

   // Expand per-lane enables to a bit mask.
   always_comb begin
      be_mask = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         be_mask[i*BYTE_W +: BYTE_W] = {BYTE_W{byte_en[i]}};
      end
   end

   // Lanes outside the byte enable must be written back exactly as read.
   always_ff @(posedge clk) begin
      if (!reset && (state_q == WRITE)) begin
         assert (((bus.mem_wdata ^ old_q) & ~be_mask) == '0);
      end
   end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit with a transaction-level model: each accepted
// request is turned into a cycle schedule and expected merged word, checked
// against the DUT every cycle. A small RAM responder serves the read port.
module tb_store_narrow_unit;

   localparam int unsigned RD_LAT = 3;

   logic clk;
   logic reset;

   store_narrow_unit_if bus ();

   store_narrow_unit #(.RD_LAT(RD_LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- RAM responder ----------------
   logic [31:0] ram [256];
   logic [31:0] rd_pipe [RD_LAT];
   logic        rd_vld  [RD_LAT];

   initial begin
      logic        r, w;
      logic [31:0] a, wd;
      for (int i = 0; i < int'(RD_LAT); i++) begin
         rd_pipe[i] = '0;
         rd_vld[i]  = 1'b0;
      end
      forever begin
         @(posedge clk);
         r  = bus.mem_rd_en;
         w  = bus.mem_wr_en;
         a  = bus.mem_addr;
         wd = bus.mem_wdata;
         #1;
         if (w === 1'b1) ram[a[9:2]] = wd;
         for (int i = int'(RD_LAT) - 1; i > 0; i--) begin
            rd_pipe[i] = rd_pipe[i-1];
            rd_vld[i]  = rd_vld[i-1];
         end
         rd_pipe[0] = ram[a[9:2]];
         rd_vld[0]  = (r === 1'b1);
         bus.mem_rdata = rd_vld[RD_LAT-1] ? rd_pipe[RD_LAT-1] : 32'hBADC_0FFE;
      end
   end

   // ---------------- Transaction model ----------------
   int          cyc = 0;
   bit          m_busy = 0;
   int          m_k, m_wr_k, m_done_k, m_acc_cyc;
   int          n_acc = 0;
   bit          m_full, m_nop, m_fault;
   logic [31:0] m_wdata, m_waddr;
   logic [31:0] m_mem [256];

   function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] d,
                                               input logic [31:0] a, input logic [1:0] s);
      int sh;
      case (s)
         2'd0: begin
            sh = 8 * int'(a[1:0]);
            return (old & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
         end
         2'd1: begin
            sh = 16 * int'(a[1]);
            return (old & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
         end
         default: return d;
      endcase
   endfunction

   task automatic model_step();
      logic [31:0] a, d;
      logic [1:0]  s;
      bit          trap;
      cyc++;
      if (reset) begin
         m_busy = 0;
      end else if (m_busy) begin
         if (m_k == m_wr_k && !m_nop) m_mem[m_waddr[9:2]] = m_wdata;
         if (m_k == m_done_k) m_busy = 0;
         else                 m_k++;
      end else if (bus.req_valid) begin
         a = bus.req_addr;
         d = bus.req_data;
         s = bus.req_size;
`ifdef MISALIGN_TRAP_EN
         trap = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
         m_fault = trap;
`else
         trap = (s == 2'd3);
         m_fault = 0;
`endif
         m_nop     = trap;
         m_full    = !trap && (s != 2'd2);
         m_waddr   = {a[31:2], 2'b00};
         m_wdata   = model_merge(m_mem[a[9:2]], d, a, s);
         m_wr_k    = m_full ? 2 + int'(RD_LAT) : 1;
         m_done_k  = m_nop ? 1 : (m_full ? 3 + int'(RD_LAT) : 2);
         m_k       = 1;
         m_busy    = 1;
         m_acc_cyc = cyc;
         n_acc++;
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // ---------------- Compare process ----------------
   int obs_rd = -1, obs_rd_prev = -1, obs_wr = -1, obs_done = -1, obs_fault = -1;

   initial forever begin
      bit exp_rd, exp_wr, exp_done;
      @(negedge clk);
      exp_rd   = m_busy && m_full && (m_k == 1);
      exp_wr   = m_busy && !m_nop && (m_k == m_wr_k);
      exp_done = m_busy && (m_k == m_done_k);
      chk("busy",      32'(bus.busy),      32'(m_busy));
      chk("req_ready", 32'(bus.req_ready), 32'(!m_busy && !reset));
      chk("done",      32'(bus.done),      32'(exp_done));
      chk("fault",     32'(bus.fault),     32'(exp_done && m_fault));
      chk("mem_rd_en", 32'(bus.mem_rd_en), 32'(exp_rd));
      chk("mem_wr_en", 32'(bus.mem_wr_en), 32'(exp_wr));
      chk("mem_wdata", bus.mem_wdata,      exp_wr ? m_wdata : 32'h0);
      if (!m_busy)                            chk("mem_addr_idle", bus.mem_addr, 32'h0);
      else if (!m_nop && (m_k <= m_wr_k))     chk("mem_addr",      bus.mem_addr, m_waddr);
      if (bus.mem_rd_en === 1'b1) begin
         obs_rd_prev = obs_rd;
         obs_rd      = cyc;
      end
      if (bus.mem_wr_en === 1'b1) obs_wr    = cyc;
      if (bus.done === 1'b1)      obs_done  = cyc;
      if (bus.fault === 1'b1)     obs_fault = cyc;
   end

   // ---------------- Stimulus ----------------
   task automatic clear_obs();
      obs_rd = -1; obs_wr = -1; obs_done = -1; obs_fault = -1;
   endtask

   task automatic preload(input int idx, input logic [31:0] w);
      ram[idx]   = w;
      m_mem[idx] = w;
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                        output int acc);
      int start;
      start         = n_acc;
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      bus.req_data  = d;
      bus.req_size  = s;
      for (int i = 0; i < 20 && n_acc == start; i++) begin
         @(posedge clk); #2;
      end
      if (n_acc == start) chk("accept_timeout", 32'(n_acc), 32'(start + 1));
      bus.req_valid = 1'b0;
      acc = m_acc_cyc;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40 && m_busy; i++) begin
         @(posedge clk); #2;
      end
      if (m_busy) chk("idle_timeout", 32'(m_busy), 32'd0);
      @(posedge clk); #2;
   endtask

   function automatic logic [31:0] rel(input int obs, input int acc);
      return (obs < 0) ? 32'hFFFF_FFFF : 32'(obs - acc + 1);
   endfunction

   initial begin
      int acc, acc1;
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int start;
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.req_data  = '0;
      bus.req_size  = '0;
      bus.mem_rdata = '0;
      for (int i = 0; i < 256; i++) preload(i, 32'h0);
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      @(posedge clk); #2;

      // 1: aligned word store, no read
      clear_obs();
      issue(32'h100, 32'hDEADBEEF, 2'b10, acc);
      wait_idle();
      chk("t1_wr_cycle",   rel(obs_wr, acc),   32'd1);
      chk("t1_done_cycle", rel(obs_done, acc), 32'd2);
      chk("t1_no_rd",      32'(obs_rd),        32'hFFFF_FFFF);
      chk("t1_ram",        ram[8'h40],         32'hDEADBEEF);

      // 2: byte store into lane 2
      preload(8'h41, 32'h11223344);
      clear_obs();
      issue(32'h106, 32'hFFFFFFAB, 2'b00, acc);
      chk("t2_model_wdata", m_wdata, 32'h11AB3344);
      wait_idle();
      chk("t2_rd_cycle",   rel(obs_rd, acc),   32'd1);
      chk("t2_wr_cycle",   rel(obs_wr, acc),   32'd5);
      chk("t2_done_cycle", rel(obs_done, acc), 32'd6);
      chk("t2_ram",        ram[8'h41],         32'h11AB3344);

      // 3: halfword store into upper half
      preload(8'h42, 32'hAABBCCDD);
      clear_obs();
      issue(32'h10A, 32'h00005566, 2'b01, acc);
      chk("t3_model_wdata", m_wdata, 32'h5566CCDD);
      wait_idle();
      chk("t3_done_cycle", rel(obs_done, acc), 32'd6);
      chk("t3_ram",        ram[8'h42],         32'h5566CCDD);

      // 4: misaligned halfword
      clear_obs();
      issue(32'h101, 32'h00001234, 2'b01, acc);
      wait_idle();
`ifdef MISALIGN_TRAP_EN
      chk("t4_done_cycle",  rel(obs_done, acc),  32'd1);
      chk("t4_fault_cycle", rel(obs_fault, acc), 32'd1);
      chk("t4_no_wr",       32'(obs_wr),         32'hFFFF_FFFF);
      chk("t4_ram",         ram[8'h40],          32'hDEADBEEF);
`else
      chk("t4_done_cycle", rel(obs_done, acc), 32'd6);
      chk("t4_no_fault",   32'(obs_fault),     32'hFFFF_FFFF);
      chk("t4_ram",        ram[8'h40],         32'hDEAD1234);
`endif

      // reserved size: no-op completion
      clear_obs();
      issue(32'h100, 32'hCAFEF00D, 2'b11, acc);
      wait_idle();
      chk("rsv_done_cycle", rel(obs_done, acc), 32'd1);
      chk("rsv_no_rd",      32'(obs_rd),        32'hFFFF_FFFF);
      chk("rsv_no_wr",      32'(obs_wr),        32'hFFFF_FFFF);
`ifdef MISALIGN_TRAP_EN
      chk("rsv_ram", ram[8'h40], 32'hDEADBEEF);
`else
      chk("rsv_ram", ram[8'h40], 32'hDEAD1234);
`endif

      // 5: reset during WAIT of a byte store aborts it
      preload(8'h43, 32'h01020304);
      clear_obs();
      issue(32'h10C, 32'h00000099, 2'b00, acc);
      @(posedge clk); #2;
      reset = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
      repeat (8) begin
         @(posedge clk); #2;
      end
      chk("t5_no_wr",   32'(obs_wr),   32'hFFFF_FFFF);
      chk("t5_no_done", 32'(obs_done), 32'hFFFF_FFFF);
      chk("t5_ram",     ram[8'h43],    32'h01020304);

      // 6: req_valid held across two byte stores
      clear_obs();
      start         = n_acc;
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h104;
      bus.req_data  = 32'h00000077;
      bus.req_size  = 2'b00;
      for (int i = 0; i < 20 && n_acc == start; i++) begin
         @(posedge clk); #2;
      end
      bus.req_addr = 32'h108;
      bus.req_data = 32'h00000088;
      for (int i = 0; i < 30 && n_acc == start + 1; i++) begin
         @(posedge clk); #2;
      end
      chk("t6_two_accepts", 32'(n_acc), 32'(start + 2));
      bus.req_valid = 1'b0;
      wait_idle();
      chk("t6_rd_gap", 32'(obs_rd - obs_rd_prev), 32'd7);
      chk("t6_ram_a",  ram[8'h41],                 32'h11AB3377);
      chk("t6_ram_b",  ram[8'h42],                 32'h5566CC88);

      for (int i = 8'h40; i <= 8'h43; i++) chk("final_ram", ram[i], m_mem[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
